// File: rtl/nibble_add_seq.sv
// nibble_add_seq: sequential WIDTH-bit adder built around one shared 4-bit
// carry-select slice. A request is taken over a valid/ready handshake and
// processed one nibble per cycle, least significant first, with the carry
// chained through a register. The result is held on a valid/ready port.
// Optional feature: define ADD_SEQ_SUB_EN to add the op_sub port (A-B).
module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Nibble views of the latched operands, selected by the nibble counter
    logic [3:0] a_nib [N];
    logic [3:0] b_nib [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_nib
        assign a_nib[gi] = a_q[4*gi +: 4];
        assign b_nib[gi] = b_q[4*gi +: 4];
    end

    logic [3:0] cur_a, cur_b;
    logic [3:0] s0, s1, nib_sum;
    logic       co0, co1, nib_co;

    // Carry-select slice: both carry cases computed, chained carry picks one
    always_comb begin
        cur_a      = a_nib[cnt_q];
        cur_b      = b_nib[cnt_q];
        {co0, s0}  = {1'b0, cur_a} + {1'b0, cur_b};
        {co1, s1}  = {1'b0, cur_a} + {1'b0, cur_b} + 5'd1;
        nib_sum    = carry_q ? s1 : s0;
        nib_co     = (co1 & carry_q) | co0;
    end

    // Next-state and datapath control; defaults hold every register
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef ADD_SEQ_SUB_EN
                    // Subtract as A + ~B + 1; cin is ignored in that mode
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
`else
                    b_d     = b;
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        sum_d[4*k +: 4] = nib_sum;
                    end
                end
                carry_d = nib_co;
                if (cnt_q == LAST) begin
                    cout_d  = nib_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed testbench for nibble_add_seq: WIDTH=16 vector table plus
// backpressure, mid-run reset and a WIDTH=4 instance.
module tb_nibble_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        op_sub = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    logic        sv4 = 1'b0, rr4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        sr4, rv4, cout4, busy4;
    logic [3:0]  sum4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nibble_add_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin),
`ifdef ADD_SEQ_SUB_EN
        .op_sub(op_sub),
`endif
        .res_valid(res_valid), .res_ready(res_ready), .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_add_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef ADD_SEQ_SUB_EN
        .op_sub(1'b0),
`endif
        .res_valid(rv4), .res_ready(rr4), .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction: accept, check busy window and latency, check result, release
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                         input logic tsub, input logic [15:0] es, input logic ec);
        int w;
        int lat;
        w = 0;
        while (!start_ready && w < 20) begin
            tick();
            w++;
        end
        chk("wait_ready", {31'd0, start_ready}, 32'd1);
        a = ta; b = tb_; cin = tc; op_sub = tsub; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~tc; op_sub = ~tsub;
        lat = 0;
        while (!res_valid && lat < 20) begin
            chk("ready_low_run", {31'd0, start_ready}, 32'd0);
            tick();
            lat++;
        end
        chk("latency", lat, 32'd4);
        chk("sum", {16'd0, sum}, {16'd0, es});
        chk("cout", {31'd0, cout}, {31'd0, ec});
        chk("ready_low_done", {31'd0, start_ready}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ready_after_take", {31'd0, start_ready}, 32'd1);
        chk("valid_after_take", {31'd0, res_valid}, 32'd0);
        $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d lat=%0d",
                 ta, tb_, tc, tsub, sum, cout, lat);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        c;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

        // Reset state
        #12;
        chk("rst_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].s, vecs[i].c);
        end

        // Backpressure: result held, start pulses ignored, no queued request
        begin
            int lat;
            a = 16'h1111; b = 16'h2222; cin = 1'b0; start_valid = 1'b1;
            tick();
            start_valid = 1'b0;
            lat = 0;
            while (!res_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk("bp_latency", lat, 32'd4);
            for (int k = 0; k < 3; k++) begin
                a = 16'h0F00; b = 16'h00F0; start_valid = (k != 1);
                tick();
                chk("bp_valid", {31'd0, res_valid}, 32'd1);
                chk("bp_sum", {16'd0, sum}, 32'h3333);
                chk("bp_cout", {31'd0, cout}, 32'd0);
                chk("bp_ready", {31'd0, start_ready}, 32'd0);
                $display("backpressure cycle %0d: sum=%h valid=%0d", k, sum, res_valid);
            end
            start_valid = 1'b0;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("bp_release_ready", {31'd0, start_ready}, 32'd1);
            tick();
            chk("bp_not_queued", {31'd0, busy}, 32'd0);
            do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);
        end

        // Asynchronous reset during the 2nd RUN cycle
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, start_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        $display("mid-run reset: sum=%h cout=%0d ready=%0d", sum, cout, start_ready);
        #2;
        rst_n = 1'b1;
        tick();
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

`ifdef ADD_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
`endif

        // WIDTH=4 instance: single RUN cycle
        chk("w4_ready", {31'd0, sr4}, 32'd1);
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; sv4 = 1'b1;
        tick();
        sv4 = 1'b0;
        chk("w4_run_valid", {31'd0, rv4}, 32'd0);
        chk("w4_run_busy", {31'd0, busy4}, 32'd1);
        tick();
        chk("w4_valid", {31'd0, rv4}, 32'd1);
        chk("w4_sum", {28'd0, sum4}, 32'h1);
        chk("w4_cout", {31'd0, cout4}, 32'd1);
        $display("w4 op a=9 b=8 -> sum=%h cout=%0d", sum4, cout4);
        rr4 = 1'b1;
        tick();
        rr4 = 1'b0;
        chk("w4_ready_after", {31'd0, sr4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
